ram_access_seq: RTL and testbench

- Initiator side of the nibble-wide RAM interface. Turns one CPU load/store request of 1-3 nibbles into back-to-back single-nibble RAM accesses.
- Assembles read nibbles into a 12-bit response, for operands and pointers.
- Sits between the CPU datapath and the 4-bit x 4096 RAM, and is the only driver of the RAM enable, address and data-in pins.

---
 rtl/ram_access_seq_if.sv | 55 +++++
 rtl/ram_access_seq.sv | 151 +++++++++++++++
 tb/tb_ram_access_seq.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_access_seq_if.sv
// rtl/ram_access_seq_if.sv - CPU request/response and RAM pin bundle for the nibble RAM sequencer
// The slave view is the sequencer; the master view is the CPU plus RAM side.
interface ram_access_seq_if #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 12
);
  logic                  req_valid_i;
  logic                  req_ready_o;
  logic                  req_we_i;
  logic [1:0]            req_len_i;
  logic [ADDR_W-1:0]     req_addr_i;
  logic [3*DATA_W-1:0]   req_wdata_i;
  logic                  rsp_valid_o;
  logic [3*DATA_W-1:0]   rsp_rdata_o;
  logic                  busy_o;
  logic                  ram_wen_o;
  logic                  ram_ren_o;
  logic [ADDR_W-1:0]     ram_addr_o;
  logic [DATA_W-1:0]     ram_din_o;
  logic [DATA_W-1:0]     ram_dout_i;

  modport slave (
    input  req_valid_i,
    input  req_we_i,
    input  req_len_i,
    input  req_addr_i,
    input  req_wdata_i,
    input  ram_dout_i,
    output req_ready_o,
    output rsp_valid_o,
    output rsp_rdata_o,
    output busy_o,
    output ram_wen_o,
    output ram_ren_o,
    output ram_addr_o,
    output ram_din_o
  );

  modport master (
    output req_valid_i,
    output req_we_i,
    output req_len_i,
    output req_addr_i,
    output req_wdata_i,
    output ram_dout_i,
    input  req_ready_o,
    input  rsp_valid_o,
    input  rsp_rdata_o,
    input  busy_o,
    input  ram_wen_o,
    input  ram_ren_o,
    input  ram_addr_o,
    input  ram_din_o
  );
endinterface

// File: rtl/ram_access_seq.sv
// rtl/ram_access_seq.sv - splits a 1..3 nibble load/store into back-to-back single-nibble RAM accesses
// Loads are fully pipelined; returned nibbles are assembled little-endian into a 12-bit response.
module ram_access_seq #(
  parameter int DATA_W       = 4,
  parameter int ADDR_W       = 12,
  parameter int READ_LATENCY = 1
) (
  input logic             clk_i,
  input logic             rst_ni,
  ram_access_seq_if.slave bus
);
  localparam int RSP_W = 3 * DATA_W;

  typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;

  state_t                  state;
  logic [1:0]              last_k;
  logic [1:0]              iss_k;
  logic [1:0]              cap_k;
  logic [RSP_W-1:0]        wdata_q;
  logic [RSP_W-1:0]        rd_buf;
  logic [RSP_W-1:0]        rd_next;
  logic [READ_LATENCY-1:0] rd_pipe;
  logic                    cap_now;

  logic                    ready_q;
  logic                    busy_q;
  logic                    rsp_valid_q;
  logic [RSP_W-1:0]        rsp_rdata_q;
  logic                    wen_q;
  logic                    ren_q;
  logic [ADDR_W-1:0]       addr_q;
  logic [DATA_W-1:0]       din_q;

  function automatic logic [DATA_W-1:0] get_nib(input logic [RSP_W-1:0] v, input logic [1:0] k);
    return v[int'(k)*DATA_W +: DATA_W];
  endfunction

  function automatic logic [RSP_W-1:0] put_nib(input logic [RSP_W-1:0] v, input logic [1:0] k,
                                               input logic [DATA_W-1:0] n);
    logic [RSP_W-1:0] r;
    r = v;
    r[int'(k)*DATA_W +: DATA_W] = n;
    return r;
  endfunction

  // rd_pipe tracks issued reads; its top bit marks the cycle whose ram_dout_i belongs to slot cap_k
  assign cap_now = rd_pipe[READ_LATENCY-1];
  assign rd_next = cap_now ? put_nib(rd_buf, cap_k, bus.ram_dout_i) : rd_buf;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= IDLE;
      last_k      <= '0;
      iss_k       <= '0;
      cap_k       <= '0;
      wdata_q     <= '0;
      rd_buf      <= '0;
      rd_pipe     <= '0;
      ready_q     <= 1'b0;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      wen_q       <= 1'b0;
      ren_q       <= 1'b0;
      addr_q      <= '0;
      din_q       <= '0;
    end else begin
      rd_pipe     <= (rd_pipe << 1) | READ_LATENCY'(ren_q);
      rsp_valid_q <= 1'b0;
      if (cap_now) begin
        rd_buf <= rd_next;
        cap_k  <= cap_k + 2'd1;
      end

      case (state)
        IDLE: begin
          if (ready_q && bus.req_valid_i) begin
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            last_k  <= (bus.req_len_i == 2'd0) ? 2'd0 : bus.req_len_i - 2'd1;
            wdata_q <= bus.req_wdata_i;
            addr_q  <= bus.req_addr_i;
            iss_k   <= '0;
            cap_k   <= '0;
            rd_buf  <= '0;
            if (bus.req_we_i) begin
              wen_q <= 1'b1;
              din_q <= get_nib(bus.req_wdata_i, 2'd0);
              state <= WRITE;
            end else begin
              ren_q <= 1'b1;
              state <= READ;
            end
          end else begin
            ready_q <= 1'b1;
          end
        end

        WRITE: begin
          if (iss_k == last_k) begin
            wen_q       <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= '0;
            state       <= DONE;
          end else begin
            iss_k  <= iss_k + 2'd1;
            addr_q <= addr_q + ADDR_W'(1);
            din_q  <= get_nib(wdata_q, iss_k + 2'd1);
          end
        end

        READ: begin
          if (iss_k == last_k) begin
            ren_q <= 1'b0;
            state <= DRAIN;
          end else begin
            iss_k  <= iss_k + 2'd1;
            addr_q <= addr_q + ADDR_W'(1);
          end
        end

        // The final nibble is folded straight into the response so DONE follows its capture cycle.
        DRAIN: begin
          if (cap_now && cap_k == last_k) begin
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= rd_next;
            state       <= DONE;
          end
        end

        DONE: begin
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          state   <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready_o = ready_q;
  assign bus.busy_o      = busy_q;
  assign bus.rsp_valid_o = rsp_valid_q;
  assign bus.rsp_rdata_o = rsp_rdata_q;
  assign bus.ram_wen_o   = wen_q;
  assign bus.ram_ren_o   = ren_q;
  assign bus.ram_addr_o  = addr_q;
  assign bus.ram_din_o   = din_q;
endmodule

// File: tb/tb_ram_access_seq.sv
// tb/tb_ram_access_seq.sv - scoreboard bench for ram_access_seq with a behavioural RAM and reference memory
module tb_ram_access_seq;
  localparam int DW = 4;
  localparam int AW = 12;
  localparam int RL = 1;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ram_access_seq_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  ram_access_seq #(.DATA_W(DW), .ADDR_W(AW), .READ_LATENCY(RL)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  typedef struct {
    bit          we;
    logic [11:0] addr;
    logic [3:0]  din;
    int          cyc;
  } acc_t;

  typedef struct {
    logic [11:0] rdata;
    int          cyc;
  } rsp_t;

  acc_t acc_q[$];
  rsp_t sb_q[$];
  logic [3:0] ref_mem [4096];

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [3:0] init_nib(input int i);
    return 4'(i * 7 + 3);
  endfunction

  // Behavioural RAM: write on the edge, read data appears RL cycles after the ren cycle, junk otherwise
  logic [3:0] ram [4096];
  logic [3:0] rd_stage [RL];
  logic       rd_vld [RL];
  logic [3:0] junk;
  bit         filled;

  always @(posedge clk) begin
    junk <= 4'($urandom);
    if (!filled) begin
      for (int i = 0; i < 4096; i++) ram[i] <= init_nib(i);
      filled <= 1'b1;
    end else if (bus.ram_wen_o) begin
      ram[bus.ram_addr_o] <= bus.ram_din_o;
    end
    rd_stage[0] <= ram[bus.ram_addr_o];
    rd_vld[0]   <= bus.ram_ren_o;
    for (int i = 1; i < RL; i++) begin
      rd_stage[i] <= rd_stage[i-1];
      rd_vld[i]   <= rd_vld[i-1];
    end
  end

  assign bus.ram_dout_i = rd_vld[RL-1] ? rd_stage[RL-1] : junk;

  // Monitor: pops expected accesses and responses as the DUT presents them
  logic [11:0] hold_exp;
  logic [11:0] last_rdata;
  bit          rsp_prev;

  always @(negedge clk) begin
    acc_t ea;
    rsp_t er;
    if (!rst_n) begin
      hold_exp = '0;
      rsp_prev = 1'b0;
    end else begin
      if (rsp_prev) begin
        check("ready_after_rsp", bus.req_ready_o, 1);
        check("busy_after_rsp", bus.busy_o, 0);
      end
      rsp_prev = 1'b0;
      if (sb_q.size() > 0) begin
        check("ready_while_busy", bus.req_ready_o, 0);
        check("busy_while_busy", bus.busy_o, 1);
      end
      check("wen_ren_exclusive", bus.ram_wen_o & bus.ram_ren_o, 0);

      while (acc_q.size() > 0 && acc_q[0].cyc < cyc) begin
        ea = acc_q.pop_front();
        check("missing_access_cycle", cyc, ea.cyc);
      end
      if (bus.ram_wen_o || bus.ram_ren_o) begin
        if (acc_q.size() == 0) begin
          check("unexpected_access", {bus.ram_wen_o, bus.ram_ren_o}, 0);
        end else begin
          ea = acc_q.pop_front();
          check("acc_wen", bus.ram_wen_o, ea.we);
          check("acc_ren", bus.ram_ren_o, !ea.we);
          check("acc_addr", bus.ram_addr_o, ea.addr);
          if (ea.we) check("acc_din", bus.ram_din_o, ea.din);
          check("acc_cycle", cyc, ea.cyc);
        end
      end

      while (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
        er = sb_q.pop_front();
        check("missing_rsp_cycle", cyc, er.cyc);
      end
      if (bus.rsp_valid_o) begin
        if (sb_q.size() == 0) begin
          check("unexpected_rsp", bus.rsp_valid_o, 0);
        end else begin
          er = sb_q.pop_front();
          check("rsp_rdata", bus.rsp_rdata_o, er.rdata);
          check("rsp_cycle", cyc, er.cyc);
          hold_exp   = er.rdata;
          last_rdata = bus.rsp_rdata_o;
          rsp_prev   = 1'b1;
        end
      end else begin
        check("rdata_hold", bus.rsp_rdata_o, hold_exp);
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 of cycle 1 after the accept edge.
  task automatic issue(input logic we, input logic [1:0] len, input logic [11:0] addr,
                       input logic [11:0] wdata, input bit keep, output int acc);
    int          n;
    int          waited;
    logic [11:0] exp;
    logic [11:0] a;
    acc_t        e;
    rsp_t        r;
    bus.req_valid_i = 1'b1;
    bus.req_we_i    = we;
    bus.req_len_i   = len;
    bus.req_addr_i  = addr;
    bus.req_wdata_i = wdata;
    n      = (len == 2'd0) ? 1 : int'(len);
    acc    = -1;
    waited = 0;
    while (acc < 0 && waited < 100) begin
      @(negedge clk);
      if (bus.req_ready_o) begin
        @(posedge clk);
        #1;
        acc = cyc;
      end else begin
        waited++;
      end
    end
    if (acc < 0) begin
      check("accept_timeout", bus.req_ready_o, 1);
      bus.req_valid_i = 1'b0;
      return;
    end
    exp = '0;
    for (int k = 0; k < n; k++) begin
      a      = addr + 12'(k);
      e.we   = we;
      e.addr = a;
      e.din  = wdata[4*k +: 4];
      e.cyc  = acc + k;
      if (we) ref_mem[a] = wdata[4*k +: 4];
      else exp[4*k +: 4] = ref_mem[a];
      acc_q.push_back(e);
    end
    r.rdata = exp;
    r.cyc   = acc + n + (we ? 0 : RL);
    sb_q.push_back(r);
    if (!keep) bus.req_valid_i = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (sb_q.size() > 0 && n < 60) begin
      @(posedge clk);
      n++;
    end
    if (sb_q.size() > 0) begin
      check("rsp_timeout", sb_q.size(), 0);
      sb_q.delete();
      acc_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, bus.req_ready_o, 0);
    check({tag, "_rsp_valid"}, bus.rsp_valid_o, 0);
    check({tag, "_rsp_rdata"}, bus.rsp_rdata_o, 0);
    check({tag, "_busy"}, bus.busy_o, 0);
    check({tag, "_wen"}, bus.ram_wen_o, 0);
    check({tag, "_ren"}, bus.ram_ren_o, 0);
    check({tag, "_addr"}, bus.ram_addr_o, 0);
    check({tag, "_din"}, bus.ram_din_o, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int  a1;
    int  a2;
    int  g;
    bit  keep;
    bit  keep_prev;
    logic [1:0]  len;
    logic [11:0] addr;

    for (int i = 0; i < 4096; i++) ref_mem[i] = init_nib(i);
    bus.req_valid_i = 1'b0;
    bus.req_we_i    = 1'b0;
    bus.req_len_i   = '0;
    bus.req_addr_i  = '0;
    bus.req_wdata_i = '0;
    rst_n = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("ready_before_first_edge", bus.req_ready_o, 0);
    @(posedge clk);
    #1;
    check("ready_after_first_edge", bus.req_ready_o, 1);

    issue(1'b1, 2'd3, 12'h010, 12'hA53, 1'b0, a1);
    wait_idle();
    issue(1'b0, 2'd3, 12'h010, 12'h000, 1'b0, a1);
    wait_idle();
    check("load_a53", last_rdata, 12'hA53);
    repeat (3) @(negedge clk);
    check("rdata_hold_a53", bus.rsp_rdata_o, 12'hA53);
    @(posedge clk);
    #1;

    issue(1'b1, 2'd2, 12'hFFF, 12'h0C7, 1'b0, a1);
    wait_idle();
    check("wrap_ram_fff", ram[12'hFFF], 4'h7);
    check("wrap_ram_000", ram[12'h000], 4'hC);
    issue(1'b0, 2'd2, 12'hFFF, 12'h000, 1'b0, a1);
    wait_idle();
    check("wrap_load", last_rdata, 12'h0C7);

    issue(1'b0, 2'd0, 12'h011, 12'hFFF, 1'b0, a1);
    wait_idle();
    check("len0_load", last_rdata, 12'h005);
    issue(1'b0, 2'd1, 12'h011, 12'hFFF, 1'b0, a1);
    wait_idle();
    check("len1_load", last_rdata, 12'h005);

    issue(1'b1, 2'd2, 12'h100, 12'h321, 1'b1, a1);
    issue(1'b1, 2'd1, 12'h200, 12'h00F, 1'b0, a2);
    check("b2b_accept_gap", a2 - a1, 4);
    wait_idle();

    issue(1'b0, 2'd3, 12'h010, 12'h000, 1'b0, a1);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    acc_q.delete();
    sb_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("midreset_ready_before_edge", bus.req_ready_o, 0);
    @(posedge clk);
    #1;
    check("midreset_ready_after_edge", bus.req_ready_o, 1);
    issue(1'b0, 2'd3, 12'h010, 12'h000, 1'b0, a1);
    wait_idle();
    check("post_reset_load", last_rdata, 12'hA53);

    keep_prev = 1'b0;
    for (int t = 0; t < 60; t++) begin
      if (!keep_prev) begin
        g = $urandom_range(0, 3);
        if (g > 0) begin
          repeat (g) @(posedge clk);
          #1;
        end
      end
      len  = 2'($urandom_range(0, 3));
      addr = ($urandom_range(0, 7) == 0) ? 12'hFFE + 12'($urandom_range(0, 1)) : 12'($urandom);
      keep = (t < 59) && ($urandom_range(0, 3) == 0);
      issue(1'($urandom), len, addr, 12'($urandom), keep, a1);
      keep_prev = keep;
    end
    wait_idle();
    check("acc_queue_drained", acc_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
